// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared button FSM state type and default 50 MHz timing constants
package stopwatch_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    CHECK_PRESS,
    PRESSED,
    CHECK_RELEASE
  } btn_state_t;

  localparam int DB_CYCLES_50M   = 500_000;
  localparam int LONG_CYCLES_50M = 100_000_000;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one key: 2-flop synchroniser, debounce FSM, press pulse, optional long-press pulse
module debounce_channel
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_50M,
  parameter int LONG_CYCLES = LONG_CYCLES_50M,
  parameter bit LONG_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic long_press
);

  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [DW-1:0] DB_ONE  = DW'(1);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  logic          sync_meta;
  logic          sync_q;
  btn_state_t    state;
  btn_state_t    state_next;
  logic [DW-1:0] db_cnt;
  logic [DW-1:0] db_cnt_next;
  logic          level_next;
  logic          press_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b1;
      sync_q    <= 1'b1;
      state     <= RELEASED;
      db_cnt    <= '0;
      level     <= 1'b1;
      press     <= 1'b0;
    end else begin
      sync_meta <= key_n;
      sync_q    <= sync_meta;
      state     <= state_next;
      db_cnt    <= db_cnt_next;
      level     <= level_next;
      press     <= press_next;
    end
  end

  // The sample must still match on the final counting cycle, else the change is rejected.
  always_comb begin
    state_next  = state;
    db_cnt_next = db_cnt;
    level_next  = level;
    press_next  = 1'b0;
    case (state)
      RELEASED: begin
        if (!sync_q) begin
          state_next  = CHECK_PRESS;
          db_cnt_next = DB_ONE;
        end
      end
      CHECK_PRESS: begin
        if (sync_q) begin
          state_next  = RELEASED;
          db_cnt_next = '0;
        end else if (db_cnt == DB_LAST) begin
          state_next  = PRESSED;
          db_cnt_next = '0;
          level_next  = 1'b0;
          press_next  = 1'b1;
        end else begin
          db_cnt_next = db_cnt + DB_ONE;
        end
      end
      PRESSED: begin
        if (sync_q) begin
          state_next  = CHECK_RELEASE;
          db_cnt_next = DB_ONE;
        end
      end
      CHECK_RELEASE: begin
        if (!sync_q) begin
          state_next  = PRESSED;
          db_cnt_next = '0;
        end else if (db_cnt == DB_LAST) begin
          state_next  = RELEASED;
          db_cnt_next = '0;
          level_next  = 1'b1;
        end else begin
          db_cnt_next = db_cnt + DB_ONE;
        end
      end
      default: begin
        state_next  = RELEASED;
        db_cnt_next = '0;
      end
    endcase
  end

  generate
    if (LONG_EN) begin : g_long
      localparam int LW = $clog2(LONG_CYCLES + 1);
      localparam logic [LW-1:0] LONG_ONE  = LW'(1);
      localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

      logic [LW-1:0] long_cnt;
      logic          long_q;

      // Saturating at LONG_LAST limits clear to one pulse per press; a release bounce keeps the count.
      always_ff @(posedge clk) begin
        if (reset) begin
          long_cnt <= '0;
          long_q   <= 1'b0;
        end else begin
          long_q <= 1'b0;
          if (press_next) begin
            long_cnt <= '0;
          end else if ((state == PRESSED || state == CHECK_RELEASE) && long_cnt != LONG_LAST) begin
            long_cnt <= long_cnt + LONG_ONE;
            long_q   <= (long_cnt + LONG_ONE == LONG_LAST);
          end
        end
      end

      assign long_press = long_q;
    end else begin : g_no_long
      assign long_press = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/stopwatch_buttons.sv
// rtl/stopwatch_buttons.sv - conditions the start_stop and hold keys feeding the Stopwatch core
module stopwatch_buttons
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_50M,
  parameter int LONG_CYCLES = LONG_CYCLES_50M
) (
  input  logic CLK_50,
  input  logic reset,
  input  logic start_stop_key_n,
  input  logic hold_key_n,
  output logic start_stop,
  output logic hold,
  output logic start_stop_press,
  output logic hold_press,
  output logic clear_req
);

  logic hold_long_unused;

  debounce_channel #(
    .DB_CYCLES  (DB_CYCLES),
    .LONG_CYCLES(LONG_CYCLES),
    .LONG_EN    (1'b1)
  ) u_start_stop (
    .clk       (CLK_50),
    .reset     (reset),
    .key_n     (start_stop_key_n),
    .level     (start_stop),
    .press     (start_stop_press),
    .long_press(clear_req)
  );

  debounce_channel #(
    .DB_CYCLES  (DB_CYCLES),
    .LONG_CYCLES(LONG_CYCLES),
    .LONG_EN    (1'b0)
  ) u_hold (
    .clk       (CLK_50),
    .reset     (reset),
    .key_n     (hold_key_n),
    .level     (hold),
    .press     (hold_press),
    .long_press(hold_long_unused)
  );

endmodule

// File: tb/tb_stopwatch_buttons.sv
// tb/tb_stopwatch_buttons.sv - directed bench with run-length behavioural model checked every cycle
module tb_stopwatch_buttons;

  localparam int DB   = 4;
  localparam int LONG = 20;

  logic clk = 1'b0;
  logic reset;
  logic start_stop_key_n;
  logic hold_key_n;
  logic start_stop;
  logic hold;
  logic start_stop_press;
  logic hold_press;
  logic clear_req;

  stopwatch_buttons #(
    .DB_CYCLES  (DB),
    .LONG_CYCLES(LONG)
  ) dut (
    .CLK_50          (clk),
    .reset           (reset),
    .start_stop_key_n(start_stop_key_n),
    .hold_key_n      (hold_key_n),
    .start_stop      (start_stop),
    .hold            (hold),
    .start_stop_press(start_stop_press),
    .hold_press      (hold_press),
    .clear_req       (clear_req)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a level flips once DB consecutive synchronised samples disagree with it.
  logic m_lvl [2] = '{1'b1, 1'b1};
  int   m_run [2] = '{0, 0};
  logic m_pls [2] = '{1'b0, 1'b0};
  logic m_d1  [2] = '{1'b1, 1'b1};
  logic m_d2  [2] = '{1'b1, 1'b1};
  int   m_age = 0;
  logic m_clr = 1'b0;

  int cyc_n = 0;
  int n_ssp = 0, ssp_at = -1;
  int n_hp = 0, hp_at = -1;
  int n_clr = 0, clr_at = -1;
  int ss_rise_at = -1, hold_rise_at = -1, hold_fall_at = -1;
  logic prev_ss = 1'b1, prev_hold = 1'b1;

  always @(posedge clk) begin
    logic pins [2];
    logic s;
    logic was_low;
    pins[0] = start_stop_key_n;
    pins[1] = hold_key_n;
    m_clr = 1'b0;
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        m_lvl[c] = 1'b1; m_run[c] = 0; m_pls[c] = 1'b0; m_d1[c] = 1'b1; m_d2[c] = 1'b1;
      end
      m_age = 0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        s = m_d2[c];
        m_d2[c] = m_d1[c];
        m_d1[c] = pins[c];
        m_pls[c] = 1'b0;
        was_low = !m_lvl[c];
        m_run[c] = (s != m_lvl[c]) ? m_run[c] + 1 : 0;
        if (m_run[c] == DB) begin
          m_lvl[c] = s;
          m_run[c] = 0;
          m_pls[c] = !s;
        end
        if (c == 0) begin
          if (m_pls[0]) m_age = 0;
          else if (was_low && m_age < LONG - 1) begin
            m_age++;
            m_clr = (m_age == LONG - 1);
          end
        end
      end
    end
    cyc_n++;
    #1;
    chk("start_stop", int'(start_stop), int'(m_lvl[0]));
    chk("hold", int'(hold), int'(m_lvl[1]));
    chk("start_stop_press", int'(start_stop_press), int'(m_pls[0]));
    chk("hold_press", int'(hold_press), int'(m_pls[1]));
    chk("clear_req", int'(clear_req), int'(m_clr));
    if (start_stop_press) begin n_ssp++; ssp_at = cyc_n; end
    if (hold_press) begin n_hp++; hp_at = cyc_n; end
    if (clear_req) begin n_clr++; clr_at = cyc_n; end
    if (start_stop && !prev_ss) ss_rise_at = cyc_n;
    if (hold && !prev_hold) hold_rise_at = cyc_n;
    if (!hold && prev_hold) hold_fall_at = cyc_n;
    prev_ss = start_stop;
    prev_hold = hold;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  int t0, b_ssp, b_hp, b_clr;
  logic [7:0] pat;

  task automatic mark();
    t0 = cyc_n; b_ssp = n_ssp; b_hp = n_hp; b_clr = n_clr;
  endtask

  initial begin
    reset = 1'b1;
    start_stop_key_n = 1'b0;
    hold_key_n = 1'b0;
    wait_n(3);
    chk("reset_ss_level", int'(start_stop), 1);
    chk("reset_hold_level", int'(hold), 1);
    chk("reset_pulses", int'(start_stop_press | hold_press | clear_req), 0);

    // keys held through reset: fresh press after release
    reset = 1'b0;
    mark();
    wait_n(10);
    chk("reset_ss_press_cycle", ssp_at - t0, 6);
    chk("reset_ss_press_count", n_ssp - b_ssp, 1);
    chk("reset_ss_level_low", int'(start_stop), 0);
    start_stop_key_n = 1'b1;
    hold_key_n = 1'b1;
    wait_n(12);

    // clean press/release on hold
    mark();
    hold_key_n = 1'b0;
    wait_n(30);
    hold_key_n = 1'b1;
    wait_n(10);
    chk("hold_press_cycle", hp_at - t0, 6);
    chk("hold_press_count", n_hp - b_hp, 1);
    chk("hold_fall_cycle", hold_fall_at - t0, 6);
    chk("hold_rise_cycle", hold_rise_at - t0, 36);

    // bounce rejection
    mark();
    pat = 8'b0000_1000;
    for (int i = 0; i < 8; i++) begin
      start_stop_key_n = pat[i];
      wait_n(1);
    end
    start_stop_key_n = 1'b1;
    wait_n(12);
    chk("bounce_press_cycle", ssp_at - t0, 10);
    chk("bounce_press_count", n_ssp - b_ssp, 1);
    chk("bounce_clear_count", n_clr - b_clr, 0);

    // long press
    mark();
    start_stop_key_n = 1'b0;
    wait_n(40);
    start_stop_key_n = 1'b1;
    wait_n(12);
    chk("long_press_cycle", ssp_at - t0, 6);
    chk("long_clear_cycle", clr_at - t0, 25);
    chk("long_clear_count", n_clr - b_clr, 1);

    // short press
    mark();
    start_stop_key_n = 1'b0;
    wait_n(15);
    start_stop_key_n = 1'b1;
    wait_n(12);
    chk("short_press_count", n_ssp - b_ssp, 1);
    chk("short_clear_count", n_clr - b_clr, 0);

    // simultaneous press, independent release
    mark();
    start_stop_key_n = 1'b0;
    hold_key_n = 1'b0;
    wait_n(8);
    hold_key_n = 1'b1;
    wait_n(7);
    start_stop_key_n = 1'b1;
    wait_n(12);
    chk("simul_ss_press_cycle", ssp_at - t0, 6);
    chk("simul_hold_press_cycle", hp_at - t0, 6);
    chk("simul_hold_rise_cycle", hold_rise_at - t0, 14);
    chk("simul_ss_rise_cycle", ss_rise_at - t0, 21);
    chk("simul_clear_count", n_clr - b_clr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
